// File: rtl/memory_arbiter.sv
// memory_arbiter
//
// Shares one single-ported memory between CHANNELS requesting masters. One
// access is issued per cycle. Grant is combinational from the request vector
// and a registered round-robin pointer, or uses fixed priority where the
// lowest channel index wins. Read grants are tracked through a tag pipeline
// READ_LATENCY stages deep, so each returning word is steered back to the
// channel that issued it, in issue order.
//
// Ports
//   clock               system clock, all state updates on its rising edge
//   reset               synchronous active-high reset
//   request             [CHANNELS]      per-channel request, held until granted
//   write_enable        [CHANNELS]      per-channel access type, 1 = write
//   address             [CHANNELS*AW]   channel k at [k*AW +: AW]
//   write_data          [CHANNELS*DW]   channel k at [k*DW +: DW]
//   grant               [CHANNELS]      one-hot or zero, access issued this cycle
//   read_valid          [CHANNELS]      one-hot or zero, read_data belongs to bit k
//   read_data           [DW]            shared read result
//   memory_write_enable                 memory write strobe
//   memory_address      [AW]            memory address
//   memory_write_data   [DW]            memory write data
//   memory_read_data    [DW]            memory read data, READ_LATENCY cycles after issue

module memory_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int CHANNELS       = 2,
  parameter int READ_LATENCY   = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [CHANNELS-1:0]               request,
  input  logic [CHANNELS-1:0]               write_enable,
  input  logic [CHANNELS*ADDRESS_WIDTH-1:0] address,
  input  logic [CHANNELS*DATA_WIDTH-1:0]    write_data,
  output logic [CHANNELS-1:0]               grant,
  output logic [CHANNELS-1:0]               read_valid,
  output logic [DATA_WIDTH-1:0]             read_data,
  output logic                              memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0]          memory_address,
  output logic [DATA_WIDTH-1:0]             memory_write_data,
  input  logic [DATA_WIDTH-1:0]             memory_read_data
);

  localparam int INDEX_WIDTH = $clog2(CHANNELS);
  localparam logic [INDEX_WIDTH:0] CHANNEL_COUNT = (INDEX_WIDTH + 1)'(CHANNELS);
  localparam logic [INDEX_WIDTH-1:0] LAST_CHANNEL = INDEX_WIDTH'(CHANNELS - 1);
  localparam int LAST_STAGE = READ_LATENCY - 1;

  logic [INDEX_WIDTH-1:0]  rr_pointer;
  logic [INDEX_WIDTH-1:0]  scan_base;
  logic [2*CHANNELS-1:0]   request_twice;
  logic [CHANNELS-1:0]     rotated_request;
  logic [INDEX_WIDTH-1:0]  winner_offset;
  logic [INDEX_WIDTH:0]    winner_sum;
  logic [INDEX_WIDTH-1:0]  winner_index;
  logic [INDEX_WIDTH-1:0]  next_pointer;
  logic                    grant_active;
  logic                    granted_read;

  logic [READ_LATENCY-1:0] tag_valid;
  logic [INDEX_WIDTH-1:0]  tag_channel [READ_LATENCY];

  // Fixed priority is a round-robin scan that always starts at channel 0.
  assign scan_base       = (FIXED_PRIORITY != 0) ? '0 : rr_pointer;
  assign request_twice   = {request, request};
  assign rotated_request = request_twice[scan_base +: CHANNELS];

  // Downward scan so the lowest set bit of the rotated vector wins.
  always_comb begin
    winner_offset = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (rotated_request[j]) winner_offset = INDEX_WIDTH'(j);
    end
  end

  // Undo the rotation: winner = (base + offset) mod CHANNELS.
  always_comb begin
    winner_sum = {1'b0, scan_base} + {1'b0, winner_offset};
    if (winner_sum >= CHANNEL_COUNT) winner_sum = winner_sum - CHANNEL_COUNT;
  end

  assign winner_index = winner_sum[INDEX_WIDTH-1:0];
  assign grant_active = (|request) && !reset;
  assign granted_read = grant_active && !write_enable[winner_index];
  assign next_pointer = (winner_index == LAST_CHANNEL) ? '0 : winner_index + 1'b1;
  assign grant        = grant_active ? (CHANNELS'(1) << winner_index) : '0;

  // The granted channel drives the memory port; an idle port is all zero.
  always_comb begin
    memory_write_enable = 1'b0;
    memory_address      = '0;
    memory_write_data   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant[k]) begin
        memory_write_enable = write_enable[k];
        memory_address      = address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        memory_write_data   = write_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The pointer only moves on a grant and never moves in fixed-priority mode.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_pointer <= '0;
    end else if ((FIXED_PRIORITY == 0) && grant_active) begin
      rr_pointer <= next_pointer;
    end
  end

  // Valid bits are reset so reads in flight at reset are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= '0;
    end else begin
      tag_valid[0] <= granted_read;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_valid[s] <= tag_valid[s-1];
      end
    end
  end

  // Channel indices are only meaningful alongside a valid bit, so no reset.
  always_ff @(posedge clock) begin
    tag_channel[0] <= winner_index;
    for (int s = 1; s < READ_LATENCY; s++) begin
      tag_channel[s] <= tag_channel[s-1];
    end
  end

  always_comb begin
    read_valid = '0;
    read_data  = '0;
    if (!reset && tag_valid[LAST_STAGE]) begin
      read_valid[tag_channel[LAST_STAGE]] = 1'b1;
      read_data = memory_read_data;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter. Three instances share one clock and reset:
//   0: defaults (2 channels, latency 1, round-robin)
//   1: 3 channels, latency 3, round-robin
//   2: 2 channels, latency 1, fixed priority
// Each cycle one instance is targeted by a vector; the others see no requests.
// Read returns are checked against a scoreboard of expected channel, data and
// arrival cycle, built from the vectors' expected grants and a reference memory.

module tb_memory_arbiter;

  typedef struct {
    int          dut;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [47:0] addr;
    logic [47:0] wdata;
    logic [2:0]  exp_grant;
    logic        exp_mem_we;
    logic [15:0] exp_mem_addr;
    logic [15:0] exp_mem_wdata;
  } vector_t;

  typedef struct {
    logic [2:0]  channel;
    logic [15:0] data;
    int          due;
  } expected_read_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req   [3];
  logic [2:0]  we    [3];
  logic [47:0] addr  [3];
  logic [47:0] wdata [3];

  logic [1:0]  d0_grant, d0_rv;
  logic [2:0]  d1_grant, d1_rv;
  logic [1:0]  d2_grant, d2_rv;
  logic [15:0] d0_rdata, d1_rdata, d2_rdata;
  logic        d0_mwe, d1_mwe, d2_mwe;
  logic [15:0] d0_maddr, d1_maddr, d2_maddr;
  logic [15:0] d0_mwdata, d1_mwdata, d2_mwdata;
  logic [15:0] d0_mrdata, d1_mrdata, d2_mrdata;

  logic [15:0] mem_model [int];
  logic [15:0] ref_mem   [int];
  logic [15:0] pipe      [3][3];

  expected_read_t sb [3][$];
  vector_t        vectors [$];

  int cycle      = 0;
  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  memory_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .CHANNELS(2),
                   .READ_LATENCY(1), .FIXED_PRIORITY(0)) dut_default (
    .clock(clock), .reset(reset), .request(req[0][1:0]), .write_enable(we[0][1:0]),
    .address(addr[0][31:0]), .write_data(wdata[0][31:0]), .grant(d0_grant),
    .read_valid(d0_rv), .read_data(d0_rdata), .memory_write_enable(d0_mwe),
    .memory_address(d0_maddr), .memory_write_data(d0_mwdata), .memory_read_data(d0_mrdata));

  memory_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .CHANNELS(3),
                   .READ_LATENCY(3), .FIXED_PRIORITY(0)) dut_three (
    .clock(clock), .reset(reset), .request(req[1]), .write_enable(we[1]),
    .address(addr[1]), .write_data(wdata[1]), .grant(d1_grant),
    .read_valid(d1_rv), .read_data(d1_rdata), .memory_write_enable(d1_mwe),
    .memory_address(d1_maddr), .memory_write_data(d1_mwdata), .memory_read_data(d1_mrdata));

  memory_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .CHANNELS(2),
                   .READ_LATENCY(1), .FIXED_PRIORITY(1)) dut_fixed (
    .clock(clock), .reset(reset), .request(req[2][1:0]), .write_enable(we[2][1:0]),
    .address(addr[2][31:0]), .write_data(wdata[2][31:0]), .grant(d2_grant),
    .read_valid(d2_rv), .read_data(d2_rdata), .memory_write_enable(d2_mwe),
    .memory_address(d2_maddr), .memory_write_data(d2_mwdata), .memory_read_data(d2_mrdata));

  assign d0_mrdata = pipe[0][0];
  assign d1_mrdata = pipe[1][2];
  assign d2_mrdata = pipe[2][0];

  function automatic int memKey(input int d, input logic [15:0] a);
    return d * 256 + int'(a[7:0]);
  endfunction

  // Unwritten locations read back a pattern unique per instance and address.
  function automatic logic [15:0] initialWord(input int d, input logic [15:0] a);
    return 16'((d + 1) * 4096 + int'(a[7:0]));
  endfunction

  function automatic int latencyOf(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic vector_t makeVector(input int d, input logic rst, input logic [2:0] rq,
                                         input logic [2:0] w, input logic [47:0] a,
                                         input logic [47:0] wd, input logic [2:0] g,
                                         input logic mwe, input logic [15:0] ma,
                                         input logic [15:0] mwd);
    vector_t v;
    v.dut = d; v.rst = rst; v.req = rq; v.we = w; v.addr = a; v.wdata = wd;
    v.exp_grant = g; v.exp_mem_we = mwe; v.exp_mem_addr = ma; v.exp_mem_wdata = mwd;
    return v;
  endfunction

  // Memory model: read happens before the write of the same edge, then the
  // returned word walks down a three-stage delay line.
  task automatic memoryCycle(input int d, input logic w, input logic [15:0] a,
                             input logic [15:0] wd);
    int key;
    key = memKey(d, a);
    pipe[d][2] = pipe[d][1];
    pipe[d][1] = pipe[d][0];
    pipe[d][0] = mem_model.exists(key) ? mem_model[key] : initialWord(d, a);
    if (w) mem_model[key] = wd;
  endtask

  always @(posedge clock) begin
    memoryCycle(0, d0_mwe, d0_maddr, d0_mwdata);
    memoryCycle(1, d1_mwe, d1_maddr, d1_mwdata);
    memoryCycle(2, d2_mwe, d2_maddr, d2_mwdata);
  end

  task automatic sampleOutputs(input int d, output logic [2:0] g, output logic [2:0] rv,
                               output logic [15:0] rd, output logic mwe,
                               output logic [15:0] ma, output logic [15:0] mwd);
    case (d)
      0: begin g = {1'b0, d0_grant}; rv = {1'b0, d0_rv}; rd = d0_rdata;
               mwe = d0_mwe; ma = d0_maddr; mwd = d0_mwdata; end
      1: begin g = d1_grant; rv = d1_rv; rd = d1_rdata;
               mwe = d1_mwe; ma = d1_maddr; mwd = d1_mwdata; end
      default: begin g = {1'b0, d2_grant}; rv = {1'b0, d2_rv}; rd = d2_rdata;
                     mwe = d2_mwe; ma = d2_maddr; mwd = d2_mwdata; end
    endcase
  endtask

  task automatic compareValue(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input vector_t v);
    int key;
    expected_read_t e;
    @(posedge clock);
    #1;
    reset = v.rst;
    for (int d = 0; d < 3; d++) begin
      req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    req[v.dut] = v.req; we[v.dut] = v.we; addr[v.dut] = v.addr; wdata[v.dut] = v.wdata;
    if (v.rst) begin
      for (int d = 0; d < 3; d++) sb[d].delete();
    end else if (v.exp_grant != 3'b000) begin
      key = memKey(v.dut, v.exp_mem_addr);
      if (v.exp_mem_we) begin
        ref_mem[key] = v.exp_mem_wdata;
      end else begin
        e.channel = v.exp_grant;
        e.data    = ref_mem.exists(key) ? ref_mem[key] : initialWord(v.dut, v.exp_mem_addr);
        e.due     = cycle + latencyOf(v.dut);
        sb[v.dut].push_back(e);
      end
    end
  endtask

  // Every instance is watched every cycle: a due entry must arrive now, and
  // anything arriving with no due entry is spurious.
  task automatic checkReadReturns();
    logic [2:0]  g, rv;
    logic [15:0] rd, ma, mwd;
    logic        mwe;
    expected_read_t e;
    for (int d = 0; d < 3; d++) begin
      sampleOutputs(d, g, rv, rd, mwe, ma, mwd);
      if (sb[d].size() != 0 && sb[d][0].due == cycle) begin
        e = sb[d].pop_front();
        compareValue($sformatf("dut%0d.read_valid", d), 16'(rv), 16'(e.channel));
        compareValue($sformatf("dut%0d.read_data", d), rd, e.data);
      end else if (rv != 3'b000) begin
        compareValue($sformatf("dut%0d.spurious_read_valid", d), 16'(rv), 16'h0000);
      end
    end
  endtask

  task automatic checkOutput(input vector_t v, input string tag);
    logic [2:0]  g, rv;
    logic [15:0] rd, ma, mwd;
    logic        mwe;
    @(negedge clock);
    sampleOutputs(v.dut, g, rv, rd, mwe, ma, mwd);
    compareValue({tag, ".grant"}, 16'(g), 16'(v.exp_grant));
    compareValue({tag, ".mem_we"}, 16'(mwe), 16'(v.exp_mem_we));
    compareValue({tag, ".mem_addr"}, ma, v.exp_mem_addr);
    compareValue({tag, ".mem_wdata"}, mwd, v.exp_mem_wdata);
    checkReadReturns();
  endtask

  task automatic runVector(input vector_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  task automatic idleCycles(input int d, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      runVector(makeVector(d, 1'b0, 3'b000, 3'b000, 48'h0, 48'h0, 3'b000, 1'b0, 16'h0, 16'h0),
                $sformatf("%s%0d", tag, i));
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      req[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
    end

    // Reset holds everything at zero even with requests present.
    vectors.push_back(makeVector(0, 1, 3'b001, 3'b001, {16'h0, 16'h0, 16'h0010}, {16'h0, 16'h0, 16'hBEEF}, 3'b000, 0, 16'h0000, 16'h0000));
    vectors.push_back(makeVector(1, 1, 3'b111, 3'b000, {16'h0043, 16'h0042, 16'h0041}, 48'h0, 3'b000, 0, 16'h0000, 16'h0000));
    // Default instance: write then read, then round-robin between two channels.
    vectors.push_back(makeVector(0, 0, 3'b001, 3'b001, {16'h0, 16'h0, 16'h0010}, {16'h0, 16'h0, 16'hBEEF}, 3'b001, 1, 16'h0010, 16'hBEEF));
    vectors.push_back(makeVector(0, 0, 3'b001, 3'b000, {16'h0, 16'h0, 16'h0010}, {16'h0, 16'h0, 16'h1234}, 3'b001, 0, 16'h0010, 16'h1234));
    vectors.push_back(makeVector(0, 0, 3'b011, 3'b011, {16'h0, 16'h0030, 16'h0020}, {16'h0, 16'h2222, 16'h1111}, 3'b010, 1, 16'h0030, 16'h2222));
    vectors.push_back(makeVector(0, 0, 3'b011, 3'b011, {16'h0, 16'h0030, 16'h0020}, {16'h0, 16'h2222, 16'h1111}, 3'b001, 1, 16'h0020, 16'h1111));
    vectors.push_back(makeVector(0, 0, 3'b011, 3'b000, {16'h0, 16'h0020, 16'h0030}, {16'h0, 16'h5555, 16'hAAAA}, 3'b010, 0, 16'h0020, 16'h5555));
    vectors.push_back(makeVector(0, 0, 3'b011, 3'b000, {16'h0, 16'h0020, 16'h0030}, {16'h0, 16'h5555, 16'hAAAA}, 3'b001, 0, 16'h0030, 16'hAAAA));
    vectors.push_back(makeVector(0, 0, 3'b000, 3'b000, {16'h0, 16'h0020, 16'h0030}, {16'h0, 16'h5555, 16'hAAAA}, 3'b000, 0, 16'h0000, 16'h0000));
    vectors.push_back(makeVector(0, 0, 3'b001, 3'b000, {16'h0, 16'h0, 16'h0005}, 48'h0, 3'b001, 0, 16'h0005, 16'h0000));
    // Three channels, latency 3: continuous rotation, then channel 1 bursts.
    vectors.push_back(makeVector(1, 0, 3'b111, 3'b000, {16'h0043, 16'h0042, 16'h0041}, 48'h0, 3'b001, 0, 16'h0041, 16'h0000));
    vectors.push_back(makeVector(1, 0, 3'b111, 3'b000, {16'h0043, 16'h0042, 16'h0041}, 48'h0, 3'b010, 0, 16'h0042, 16'h0000));
    vectors.push_back(makeVector(1, 0, 3'b111, 3'b000, {16'h0043, 16'h0042, 16'h0041}, 48'h0, 3'b100, 0, 16'h0043, 16'h0000));
    vectors.push_back(makeVector(1, 0, 3'b111, 3'b000, {16'h0043, 16'h0042, 16'h0041}, 48'h0, 3'b001, 0, 16'h0041, 16'h0000));
    vectors.push_back(makeVector(1, 0, 3'b010, 3'b000, {16'h0, 16'h0050, 16'h0}, 48'h0, 3'b010, 0, 16'h0050, 16'h0000));
    vectors.push_back(makeVector(1, 0, 3'b010, 3'b000, {16'h0, 16'h0051, 16'h0}, 48'h0, 3'b010, 0, 16'h0051, 16'h0000));
    vectors.push_back(makeVector(1, 0, 3'b010, 3'b000, {16'h0, 16'h0052, 16'h0}, 48'h0, 3'b010, 0, 16'h0052, 16'h0000));
    vectors.push_back(makeVector(1, 0, 3'b100, 3'b100, {16'h0060, 16'h0, 16'h0}, {16'hCAFE, 16'h0, 16'h0}, 3'b100, 1, 16'h0060, 16'hCAFE));
    vectors.push_back(makeVector(1, 0, 3'b001, 3'b000, {16'h0, 16'h0, 16'h0060}, 48'h0, 3'b001, 0, 16'h0060, 16'h0000));
    // Fixed priority: channel 0 holds the port until it drops its request.
    vectors.push_back(makeVector(2, 0, 3'b011, 3'b000, {16'h0, 16'h0071, 16'h0070}, 48'h0, 3'b001, 0, 16'h0070, 16'h0000));
    vectors.push_back(makeVector(2, 0, 3'b011, 3'b000, {16'h0, 16'h0071, 16'h0070}, 48'h0, 3'b001, 0, 16'h0070, 16'h0000));
    vectors.push_back(makeVector(2, 0, 3'b010, 3'b000, {16'h0, 16'h0071, 16'h0070}, 48'h0, 3'b010, 0, 16'h0071, 16'h0000));
    vectors.push_back(makeVector(2, 0, 3'b011, 3'b011, {16'h0, 16'h0081, 16'h0080}, {16'h0, 16'h0B0B, 16'h0A0A}, 3'b001, 1, 16'h0080, 16'h0A0A));
    vectors.push_back(makeVector(2, 0, 3'b000, 3'b000, 48'h0, 48'h0, 3'b000, 0, 16'h0000, 16'h0000));

    for (int i = 0; i < vectors.size(); i++) begin
      runVector(vectors[i], $sformatf("v%0d", i));
    end

    // Ten idle cycles must leave the default instance's pointer at channel 1.
    idleCycles(0, 10, "idle");
    runVector(makeVector(0, 0, 3'b011, 3'b000, {16'h0, 16'h0030, 16'h0010}, 48'h0, 3'b010, 0, 16'h0030, 16'h0000), "after_idle0");
    runVector(makeVector(0, 0, 3'b011, 3'b000, {16'h0, 16'h0030, 16'h0010}, 48'h0, 3'b001, 0, 16'h0010, 16'h0000), "after_idle1");

    // A read in flight when reset hits must never return, and the pointer
    // (channel 2 without the reset) restarts at channel 0.
    runVector(makeVector(1, 0, 3'b010, 3'b000, {16'h0, 16'h0055, 16'h0}, 48'h0, 3'b010, 0, 16'h0055, 16'h0000), "flush_read");
    runVector(makeVector(1, 1, 3'b010, 3'b000, {16'h0, 16'h0055, 16'h0}, 48'h0, 3'b000, 0, 16'h0000, 16'h0000), "flush_reset");
    idleCycles(1, 5, "flush_idle");
    runVector(makeVector(1, 0, 3'b111, 3'b000, {16'h0043, 16'h0042, 16'h0041}, 48'h0, 3'b001, 0, 16'h0041, 16'h0000), "post_reset");

    idleCycles(0, 5, "drain");
    for (int d = 0; d < 3; d++) begin
      compareValue($sformatf("dut%0d.reads_outstanding", d), 16'(sb[d].size()), 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: data word width in bits.
REQ-002 Parameter ADDRESS_WIDTH, default 16: address width in bits.
REQ-003 Parameter CHANNELS, default 2: number of requesting masters; legal range 2..8.
REQ-004 Parameter READ_LATENCY, default 1: cycles from memory address issue to valid memory_read_data; legal range 1..4.
REQ-005 Parameter FIXED_PRIORITY, default 0: 0 selects round-robin arbitration; 1 selects fixed priority, lowest channel index wins.
REQ-006 clock  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 request  input  CHANNELS  per-channel access request, held high until granted.
REQ-009 write_enable  input  CHANNELS  per-channel access type: 1 = write, 0 = read.
REQ-010 address  input  CHANNELS*ADDRESS_WIDTH  per-channel address; channel k occupies bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-011 write_data  input  CHANNELS*DATA_WIDTH  per-channel write data, packed the same way as address.
REQ-012 grant  output  CHANNELS  one-hot or zero; bit k high means channel k's access is issued this cycle.
REQ-013 read_valid  output  CHANNELS  one-hot or zero; bit k high means read_data holds channel k's read result this cycle.
REQ-014 read_data  output  DATA_WIDTH  read result, shared by all channels.
REQ-015 memory_write_enable  output  1  memory write strobe.
REQ-016 memory_address  output  ADDRESS_WIDTH  memory address.
REQ-017 memory_write_data  output  DATA_WIDTH  memory write data.
REQ-018 memory_read_data  input  DATA_WIDTH  memory read data, valid READ_LATENCY cycles after its address is issued.

Function
REQ-019 Grant shall be combinational from request and the priority pointer; at most one grant bit shall be high per cycle, and grant shall be zero when request is zero.
REQ-020 The memory shall accept one access per cycle; a granted channel's address, write_data and write_enable shall drive memory_address, memory_write_data and memory_write_enable in the grant cycle.
REQ-021 With no grant, memory_write_enable shall be 0 and memory_address and memory_write_data shall be 0.
REQ-022 Round-robin mode: a registered pointer P shall name the highest-priority channel; the winner is the first requesting channel scanning P, P+1, ... modulo CHANNELS.
REQ-023 Round-robin mode: after a grant to channel k, P shall become (k+1) modulo CHANNELS on the next edge; P shall hold when no grant occurs.
REQ-024 Fixed-priority mode: the lowest-index requesting channel shall win, and P shall be unused.
REQ-025 A read grant shall enter a READ_LATENCY-deep tag pipeline (valid bit plus channel index); write grants shall enter no tag.
REQ-026 read_valid bit k shall be high exactly READ_LATENCY cycles after a read grant to channel k, for one cycle; read_data shall equal memory_read_data in that cycle.
REQ-027 Back-to-back reads, from one channel or several, shall each return in issue order with no bubbles; a read and a write may issue in consecutive cycles.
REQ-028 Reads from one channel shall never be reordered, and no read_valid shall be emitted without a matching prior read grant.
REQ-029 A channel that drops request before grant shall receive no grant; its address is not issued.

Reset
REQ-030 While reset is high: grant = 0, read_valid = 0, memory_write_enable = 0, memory_address = 0, memory_write_data = 0, P = 0, all tag valid bits cleared.
REQ-031 Reads in flight when reset asserts shall be discarded and produce no read_valid after reset deasserts.
REQ-032 In the first cycle after reset deasserts, arbitration shall resume with P = 0.

Verification
REQ-033 Defaults; channel 0 writes 0xBEEF to 0x0010, then reads 0x0010 -> grant=01 both cycles, memory_write_enable=1 then 0; read_valid=01 with read_data=0xBEEF one cycle after the read grant.
REQ-034 CHANNELS=3, round-robin, all three request reads continuously -> grants 001, 010, 100, 001, ... with no idle cycle; read_valid follows the same sequence READ_LATENCY cycles later.
REQ-035 FIXED_PRIORITY=1, channels 0 and 1 request continuously -> grant stays 01; channel 1 is granted in the cycle after channel 0 drops request.
REQ-036 READ_LATENCY=3, channel 1 reads at cycles 0, 1 and 2 -> read_valid=10 at cycles 3, 4 and 5 with data in issue order.
REQ-037 READ_LATENCY=3, a read is granted, then reset is asserted at cycle 1 for one cycle -> read_valid stays 0 through cycle 6; the next grant follows P = 0.
REQ-038 No requests for 10 cycles -> grant=0, memory_write_enable=0 and P unchanged throughout.
